fft_twiddle_mul: RTL and testbench

//  Pipelined complex multiplier applying the FFT twiddle factor W_N^k to each valid sample.

---
 rtl/fft_pkg.sv | 54 +++++
 rtl/fft_twiddle_rom.sv | 16 +
 rtl/fft_twiddle_mul.sv | 158 +++++++++++++++
 tb/tb_fft_twiddle_mul.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types, constants and twiddle ROM function for the FFT twiddle multiplier.
// tw_lookup(k, n, frac) returns {c, s} = W_n^k; valid for power-of-2 n from 4 to 64.
package fft_pkg;

   localparam int DW_DEF     = 32;
   localparam int FRAC_DEF   = 16;
   localparam int ROUND_HALF = 1 << (FRAC_DEF - 1);
   localparam int TW_W       = 32;
   localparam int TW_STEPS   = 64;
   localparam int QW         = 5;

   typedef struct packed {
      logic signed [DW_DEF-1:0] re;
      logic signed [DW_DEF-1:0] im;
   } cplx_t;

   typedef struct packed {
      logic signed [TW_W-1:0] c;
      logic signed [TW_W-1:0] s;
   } tw_t;

   // cos(2*pi*i/64) in Q16, quarter wave i = 0..16
   localparam int QTAB [0:16] = '{
      65536, 65220, 64277, 62714, 60547, 57798, 54491, 50660,
      46341, 41576, 36410, 30893, 25080, 19024, 12785, 6424, 0
   };

   function automatic int tw_scale(input int v, input int frac);
      if (frac >= 16) return v <<< (frac - 16);
      return (v + (1 <<< (15 - frac))) >>> (16 - frac);
   endfunction

   // Angle index i in 64ths of a turn; k < n/2 keeps i in 0..31,
   // so only the first two quadrants are folded onto the table.
   function automatic tw_t tw_lookup(input int k, input int n,
                                     input int frac = FRAC_DEF);
      tw_t w;
      int  i;
      int  cv;
      int  sv;
      i = (k * (TW_STEPS / n)) % TW_STEPS;
      if (i <= TW_STEPS / 4) begin
         cv = QTAB[QW'(i)];
         sv = QTAB[QW'(TW_STEPS / 4 - i)];
      end else begin
         cv = -QTAB[QW'(TW_STEPS / 2 - i)];
         sv = QTAB[QW'(i - TW_STEPS / 4)];
      end
      w.c = tw_scale(cv, frac);
      w.s = tw_scale(sv, frac);
      return w;
   endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Combinational twiddle ROM: index k -> {c, s} with W = c - j*s.
// Ports: k (twiddle index, $clog2(N/2) bits), w ({c, s} coefficient pair).
module fft_twiddle_rom
   import fft_pkg::*;
#(
   parameter int N    = 16,
   parameter int FRAC = FRAC_DEF,
   localparam int KW  = $clog2(N / 2)
) (
   input  logic [KW-1:0] k,
   output tw_t           w
);

   always_comb w = tw_lookup(int'(k), N, FRAC);

endmodule

// File: rtl/fft_twiddle_mul.sv
// 3-stage complex multiplier applying W_N^k (k from internal sample counter).
// Ports: clk, rst (async active-low), valid_in, frame_start, real_in, imag_in,
//        valid_out, real_out, imag_out, k_out.
// Macro FFT_TWM_SAT_EN: saturate results to DW bits; undefined wraps instead.
module fft_twiddle_mul
   import fft_pkg::*;
#(
   parameter int DW   = DW_DEF,
   parameter int FRAC = FRAC_DEF,
   parameter int N    = 16,
   localparam int KW  = $clog2(N / 2)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid_in,
   input  logic          frame_start,
   input  logic [DW-1:0] real_in,
   input  logic [DW-1:0] imag_in,
   output logic          valid_out,
   output logic [DW-1:0] real_out,
   output logic [DW-1:0] imag_out,
   output logic [KW-1:0] k_out
);

   localparam int PW = 2 * DW;
   localparam int SW = PW + 2;
   localparam logic signed [SW-1:0] RND = SW'(1) <<< (FRAC - 1);

   logic [KW-1:0] cnt;
   logic [KW-1:0] k_cur;

   // frame_start forces k=0 for a coincident sample
   assign k_cur = frame_start ? '0 : cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (valid_in) begin
         cnt <= k_cur + KW'(1);
      end else if (frame_start) begin
         cnt <= '0;
      end
   end

   // S1: operand and index
   logic                 v1;
   logic signed [DW-1:0] a1;
   logic signed [DW-1:0] b1;
   logic [KW-1:0]        k1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1 <= 1'b0;
         a1 <= '0;
         b1 <= '0;
         k1 <= '0;
      end else begin
         v1 <= valid_in;
         if (valid_in) begin
            a1 <= real_in;
            b1 <= imag_in;
            k1 <= k_cur;
         end
      end
   end

   tw_t                  w;
   logic signed [DW-1:0] c1;
   logic signed [DW-1:0] s1;

   fft_twiddle_rom #(
      .N    (N),
      .FRAC (FRAC)
   ) u_rom (
      .k (k1),
      .w (w)
   );

   assign c1 = DW'(w.c);
   assign s1 = DW'(w.s);

   // S2: full-width products
   logic                 v2;
   logic [KW-1:0]        k2;
   logic signed [PW-1:0] p_ac;
   logic signed [PW-1:0] p_bs;
   logic signed [PW-1:0] p_as;
   logic signed [PW-1:0] p_bc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v2   <= 1'b0;
         k2   <= '0;
         p_ac <= '0;
         p_bs <= '0;
         p_as <= '0;
         p_bc <= '0;
      end else begin
         v2 <= v1;
         if (v1) begin
            k2   <= k1;
            p_ac <= PW'(a1) * PW'(c1);
            p_bs <= PW'(b1) * PW'(s1);
            p_as <= PW'(a1) * PW'(s1);
            p_bc <= PW'(b1) * PW'(c1);
         end
      end
   end

   // S3: combine, round half up, reduce
   logic signed [SW-1:0] sh_re;
   logic signed [SW-1:0] sh_im;
   logic [DW-1:0]        res_re;
   logic [DW-1:0]        res_im;

   always_comb begin
      sh_re = (SW'(p_ac) + SW'(p_bs) + RND) >>> FRAC;
      sh_im = (SW'(p_bc) - SW'(p_as) + RND) >>> FRAC;
   end

`ifdef FFT_TWM_SAT_EN
   localparam logic signed [SW-1:0] SMAX =
      {{(SW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
   localparam logic signed [SW-1:0] SMIN = ~SMAX;

   always_comb begin
      res_re = sh_re[DW-1:0];
      res_im = sh_im[DW-1:0];
      if (sh_re > SMAX) res_re = SMAX[DW-1:0];
      if (sh_re < SMIN) res_re = SMIN[DW-1:0];
      if (sh_im > SMAX) res_im = SMAX[DW-1:0];
      if (sh_im < SMIN) res_im = SMIN[DW-1:0];
   end
`else
   logic unused_hi;

   assign res_re    = sh_re[DW-1:0];
   assign res_im    = sh_im[DW-1:0];
   assign unused_hi = ^{sh_re[SW-1:DW], sh_im[SW-1:DW]};
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_out <= 1'b0;
         real_out  <= '0;
         imag_out  <= '0;
         k_out     <= '0;
      end else begin
         valid_out <= v2;
         if (v2) begin
            real_out <= res_re;
            imag_out <= res_im;
            k_out    <= k2;
         end
      end
   end

endmodule

// File: tb/tb_fft_twiddle_mul.sv
// Directed bench for fft_twiddle_mul (DW=32, FRAC=16, N=16).
// Table of streamed vectors plus sequences for bubbles, saturation and reset.
module tb_fft_twiddle_mul;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic        frame_start;
   logic [31:0] real_in;
   logic [31:0] imag_in;
   logic        valid_out;
   logic [31:0] real_out;
   logic [31:0] imag_out;
   logic [2:0]  k_out;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fft_twiddle_mul #(
      .DW   (32),
      .FRAC (16),
      .N    (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .valid_in    (valid_in),
      .frame_start (frame_start),
      .real_in     (real_in),
      .imag_in     (imag_in),
      .valid_out   (valid_out),
      .real_out    (real_out),
      .imag_out    (imag_out),
      .k_out       (k_out)
   );

   typedef struct {
      logic        fs;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] re;
      logic [31:0] im;
      logic [2:0]  k;
   } vec_t;

   vec_t vec [9];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic fs,
                        input logic [31:0] a, input logic [31:0] b);
      valid_in    = v;
      frame_start = fs;
      real_in     = a;
      imag_in     = b;
   endtask

   task automatic chk_out(input string name, input logic [31:0] re,
                          input logic [31:0] im, input logic [2:0] k);
      chk({name, " valid"}, 32'(valid_out), 32'd1);
      chk({name, " re"}, real_out, re);
      chk({name, " im"}, imag_out, im);
      chk({name, " k"}, 32'(k_out), 32'(k));
   endtask

   logic [0:14] pat;
   logic [0:17] pat_d;
   int          n_in;
   int          n_out;
   logic [31:0] sat_exp;

   initial begin
      vec[0] = '{1'b1, 32'h00010000, 32'h00020000,
                 32'h00010000, 32'h00020000, 3'd0};
      vec[1] = '{1'b0, 32'h00010000, 32'h00000000,
                 32'h0000EC83, 32'hFFFF9E08, 3'd1};
      vec[2] = '{1'b0, 32'h00000001, 32'h00000000,
                 32'h00000001, 32'hFFFFFFFF, 3'd2};
      vec[3] = '{1'b0, 32'h00000000, 32'h00010000,
                 32'h0000EC83, 32'h000061F8, 3'd3};
      vec[4] = '{1'b0, 32'h00010000, 32'h00000000,
                 32'h00000000, 32'hFFFF0000, 3'd4};
      vec[5] = '{1'b0, 32'h00010000, 32'h00010000,
                 32'h00008A8B, 32'hFFFEB185, 3'd5};
      vec[6] = '{1'b0, 32'hFFFF0000, 32'h00000000,
                 32'h0000B505, 32'h0000B505, 3'd6};
      vec[7] = '{1'b0, 32'h00008000, 32'h00000000,
                 32'hFFFF89BF, 32'hFFFFCF04, 3'd7};
      vec[8] = '{1'b0, 32'h12345678, 32'h9ABCDEF0,
                 32'h12345678, 32'h9ABCDEF0, 3'd0};

      rst = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) step();
      rst = 1'b1;
      step();
      chk("reset valid", 32'(valid_out), 32'd0);
      chk("reset re", real_out, 32'd0);
      chk("reset im", imag_out, 32'd0);
      chk("reset k", 32'(k_out), 32'd0);

      // streamed table, one frame k=0..7 then wrap to 0
      for (int i = 0; i < 11; i++) begin
         if (i < 9) drive(1'b1, vec[i].fs, vec[i].a, vec[i].b);
         else drive(1'b0, 1'b0, 32'h0, 32'h0);
         step();
         if (i >= 2)
            chk_out($sformatf("vec%0d", i - 2), vec[i-2].re,
                    vec[i-2].im, vec[i-2].k);
      end

      repeat (3) step();
      chk("hold valid", 32'(valid_out), 32'd0);
      chk("hold re", real_out, 32'h12345678);
      chk("hold im", imag_out, 32'h9ABCDEF0);

      // -j rotation: idle frame_start, then 5 samples
      drive(1'b0, 1'b1, 32'h0, 32'h0);
      step();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 32'h00010000, 32'h0);
         step();
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) step();
      chk_out("rot5", 32'h00000000, 32'hFFFF0000, 3'd4);

      // wrap with bubbles
      pat   = 15'b101100101101101;
      pat_d = '0;
      n_in  = 0;
      n_out = 0;
      for (int i = 0; i < 18; i++) begin
         if (i < 15) begin
            drive(pat[i], i == 0, 32'(i), 32'h0);
            pat_d[i] = pat[i];
            if (pat[i]) n_in++;
         end else begin
            drive(1'b0, 1'b0, 32'h0, 32'h0);
         end
         step();
         if (i >= 2) begin
            chk($sformatf("bub v%0d", i), 32'(valid_out),
                32'(pat_d[i-2]));
            if (pat_d[i-2]) begin
               chk($sformatf("bub k%0d", n_out), 32'(k_out),
                   32'(n_out % 8));
               n_out++;
            end
         end
      end
      chk("bub count", 32'(n_out), 32'(n_in));

      // saturation at k=2
      drive(1'b1, 1'b1, 32'h0, 32'h0);
      step();
      drive(1'b1, 1'b0, 32'h0, 32'h0);
      step();
      drive(1'b1, 1'b0, 32'h7FFF0000, 32'h7FFF0000);
      step();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) step();
`ifdef FFT_TWM_SAT_EN
      sat_exp = 32'h7FFFFFFF;
`else
      sat_exp = 32'hB50395F6;
`endif
      chk_out("sat", sat_exp, 32'h00000000, 3'd2);

      // rounding at k=2
      drive(1'b1, 1'b1, 32'h0, 32'h0);
      step();
      drive(1'b1, 1'b0, 32'h0, 32'h0);
      step();
      drive(1'b1, 1'b0, 32'h00000001, 32'h0);
      step();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) step();
      chk_out("round", 32'h00000001, 32'hFFFFFFFF, 3'd2);

      // reset with two samples in flight
      drive(1'b1, 1'b1, 32'h00050000, 32'h00060000);
      step();
      drive(1'b1, 1'b0, 32'h00070000, 32'h00080000);
      step();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      rst = 1'b0;
      #3;
      chk("rst async valid", 32'(valid_out), 32'd0);
      chk("rst async re", real_out, 32'd0);
      step();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("rst flush %0d", i), 32'(valid_out), 32'd0);
      end
      drive(1'b1, 1'b0, 32'h00030000, 32'hFFFD0000);
      step();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) step();
      chk_out("post rst", 32'h00030000, 32'hFFFD0000, 3'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
